reg_file: RTL and testbench
===========================

REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; ports clock and reset.
REQ-002 clock  input  1  rising-edge clock; all state updates on posedge clock.
REQ-003 reset  input  1  synchronous active-high reset, sampled on posedge clock.
REQ-004 addr  input  4  register index 0..15 for read and write.
REQ-005 data_in  input  4  write data.
REQ-006 write_enable  input  1  write qualifier; effective only with select=1.
REQ-007 select  input  1  block select; 0 = no access, state and outputs hold.
REQ-008 data_out  output  4  registered read data.
REQ-009 pair_data_out  output  8  combinational register-pair view of pair addr[3:1].
REQ-010 The block SHALL interpret any non-1 value (0, X, Z) on reset, select or write_enable as inactive, so it tolerates unconnected control inputs.

Function
REQ-011 Storage SHALL be 16 independent 4-bit registers R0..R15.
REQ-012 Write: on posedge with reset=0, select=1, write_enable=1 -> R[addr] <= data_in; visible to reads from the next cycle.
REQ-013 Read: on posedge with reset=0, select=1, write_enable=0 -> data_out <= R[addr]; one-cycle latency from addr/select setup to valid data_out.
REQ-014 Simultaneous write and select (select=1, write_enable=1): data_out SHALL take data_in on the same edge (write-through).
REQ-015 select=0: no register changes and data_out SHALL hold its previous value regardless of addr, data_in and write_enable.
REQ-016 write_enable=1 with select=0 SHALL NOT modify any register.
REQ-017 Only the addressed register SHALL change on a write; all 15 others SHALL hold.
REQ-018 pair_data_out SHALL equal {R[{addr[3:1],1'b0}], R[{addr[3:1],1'b1}]}; even register is the high nibble.
REQ-019 pair_data_out SHALL reflect a write combinationally from the edge that performs it, with no extra latency.
REQ-020 Addresses SHALL cover all 16 values with no wrap or aliasing; addr=15 and addr=0 behave identically to the other addresses.
REQ-021 Back-to-back accesses (write then read of the same address on consecutive edges) SHALL return the newly written value.

Reset
REQ-022 On posedge with reset=1, all of R0..R15 SHALL clear to 0 and data_out SHALL clear to 0.
REQ-023 Reset SHALL take priority over any simultaneous write or read on the same edge; the write is discarded.
REQ-024 After reset deasserts, pair_data_out SHALL read 8'h00 for every pair until a register is written.
REQ-025 Without an asserted reset, register contents SHALL be undefined until written; no initial-value dependency.

Verification
REQ-026 Exhaustive: write R[i]=i for i=0..15 (select=1, write_enable=1, one per cycle), then read each i -> data_out==i one cycle after select, all 16 pass.
REQ-027 Reset mid-operation: write R5=4'hA, assert reset one cycle with write_enable=1 addr=5 data_in=4'h3 -> read R5 returns 0, data_out==0 right after reset.
REQ-028 Gated write: select=0, write_enable=1, addr=7, data_in=4'hF after R7=4'h2 -> read R7 returns 4'h2; data_out unchanged during the select=0 cycle.
REQ-029 Write-through: select=1, write_enable=1, addr=3, data_in=4'h9 -> data_out==4'h9 after that edge; next read of R3 returns 4'h9.
REQ-030 Pair view: R4=4'hC, R5=4'h6, addr=4 or 5 -> pair_data_out==8'hC6; R14=4'h1, R15=4'hE, addr=15 -> 8'h1E.
REQ-031 Isolation: write R0=4'h5 then write R1=4'hA -> R0 still reads 4'h5, all other registers unchanged.

Source files
------------

// File: rtl/reg_file_if.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_if
// Purpose  : Access bus for reg_file (address, write data, qualifiers, reads)
// Revision : 1.0
// ============================================================================
interface reg_file_if;
    logic [3:0] addr;
    logic [3:0] data_in;
    logic       write_enable;
    logic       select;
    logic [3:0] data_out;
    logic [7:0] pair_data_out;

    modport master (
        output addr,
        output data_in,
        output write_enable,
        output select,
        input  data_out,
        input  pair_data_out
    );

    modport slave (
        input  addr,
        input  data_in,
        input  write_enable,
        input  select,
        output data_out,
        output pair_data_out
    );
endinterface
`default_nettype wire

// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
// Module   : reg_file
// Purpose  : 16 x 4-bit register file, registered read, write-through,
//            combinational even/odd register-pair view
// Revision : 1.0
// ============================================================================
module reg_file (
    input  wire        clock,
    input  wire        reset,
    reg_file_if.slave  bus
);
    localparam int c_DEPTH = 16;

    logic [3:0] r_mem [c_DEPTH];
    logic [3:0] r_data_out;
    logic [3:0] w_even_idx;
    logic [3:0] w_odd_idx;

    // Plain if() treats X/Z on reset, select and write_enable as inactive.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem[i] <= 4'h0;
            end
            r_data_out <= 4'h0;
        end else if (bus.select) begin
            if (bus.write_enable) begin
                r_mem[bus.addr] <= bus.data_in;
                r_data_out      <= bus.data_in;
            end else begin
                r_data_out      <= r_mem[bus.addr];
            end
        end
    end

    assign w_even_idx        = {bus.addr[3:1], 1'b0};
    assign w_odd_idx         = {bus.addr[3:1], 1'b1};
    assign bus.data_out      = r_data_out;
    assign bus.pair_data_out = {r_mem[w_even_idx], r_mem[w_odd_idx]};
endmodule
`default_nettype wire

// File: tb/tb_reg_file.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file
// Purpose  : Directed scoreboard bench for reg_file
// Revision : 1.0
// ============================================================================
module tb_reg_file;
    typedef struct {
        logic       chk_d;
        logic [3:0] exp_d;
        logic       chk_p;
        logic [7:0] exp_p;
        string      name;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    reg_file_if bus ();

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    reg_file u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Drive one cycle at the falling edge and queue what the following rising edge must produce.
    task automatic op(input logic rst, input logic sel, input logic we,
                      input logic [3:0] a, input logic [3:0] d,
                      input logic cd, input logic [3:0] ed,
                      input logic cp, input logic [7:0] ep, input string nm);
        exp_t e;
        @(negedge clock);
        reset            = rst;
        bus.select       = sel;
        bus.write_enable = we;
        bus.addr         = a;
        bus.data_in      = d;
        e.chk_d = cd; e.exp_d = ed; e.chk_p = cp; e.exp_p = ep; e.name = nm;
        sb.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.chk_d) begin
                    n_cmp++;
                    if (bus.data_out !== e.exp_d) begin
                        n_fail++;
                        $display("FAIL %s: data_out=%h required %h", e.name, bus.data_out, e.exp_d);
                    end
                end
                if (e.chk_p) begin
                    n_cmp++;
                    if (bus.pair_data_out !== e.exp_p) begin
                        n_fail++;
                        $display("FAIL %s: pair_data_out=%h required %h", e.name, bus.pair_data_out, e.exp_p);
                    end
                end
            end
        end
    end

    initial begin : driver
        logic [3:0] v;
        int         guard;
        reset = 1'b1; bus.select = 1'b0; bus.write_enable = 1'b0;
        bus.addr = 4'h0; bus.data_in = 4'h0;

        // Reset wins over a simultaneous write.
        op(1, 1, 1, 4'h3, 4'h5, 1, 4'h0, 1, 8'h00, "reset_with_write");
        for (int i = 0; i < 16; i += 2) begin
            v = 4'(i);
            op(0, 0, 0, v, 4'h0, 1, 4'h0, 1, 8'h00, "post_reset_pair");
        end

        // Exhaustive write R[i]=i with write-through, then read back.
        for (int i = 0; i < 16; i++) begin
            v = 4'(i);
            if (i % 2 == 0)
                op(0, 1, 1, v, v, 1, v, 1, {v, 4'h0}, "exh_write");
            else
                op(0, 1, 1, v, v, 1, v, 1, {4'(i - 1), v}, "exh_write");
        end
        for (int i = 0; i < 16; i++) begin
            v = 4'(i);
            op(0, 1, 0, v, 4'hF, 1, v, 1, {4'(i & 14), 4'(i | 1)}, "exh_read");
        end

        // Isolation: R0/R1 rewritten, all others keep their index value.
        op(0, 1, 1, 4'h0, 4'h5, 1, 4'h5, 1, 8'h51, "iso_write_r0");
        op(0, 1, 1, 4'h1, 4'hA, 1, 4'hA, 1, 8'h5A, "iso_write_r1");
        op(0, 1, 0, 4'h0, 4'h0, 1, 4'h5, 1, 8'h5A, "iso_read_r0");
        op(0, 1, 0, 4'h1, 4'h0, 1, 4'hA, 1, 8'h5A, "iso_read_r1");
        for (int i = 2; i < 16; i++) begin
            v = 4'(i);
            op(0, 1, 0, v, 4'h0, 1, v, 0, 8'h00, "iso_read_other");
        end

        // Pair view.
        op(0, 1, 1, 4'h4, 4'hC, 1, 4'hC, 1, 8'hC5, "pair_write_r4");
        op(0, 1, 1, 4'h5, 4'h6, 1, 4'h6, 1, 8'hC6, "pair_write_r5");
        op(0, 1, 0, 4'h4, 4'h0, 1, 4'hC, 1, 8'hC6, "pair_read_4");
        op(0, 1, 0, 4'h5, 4'h0, 1, 4'h6, 1, 8'hC6, "pair_read_5");
        op(0, 1, 1, 4'hE, 4'h1, 1, 4'h1, 1, 8'h1F, "pair_write_r14");
        op(0, 1, 1, 4'hF, 4'hE, 1, 4'hE, 1, 8'h1E, "pair_write_r15");
        op(0, 1, 0, 4'hF, 4'h0, 1, 4'hE, 1, 8'h1E, "pair_read_15");

        // Gated write: select=0 leaves R7 and data_out alone.
        op(0, 1, 1, 4'h7, 4'h2, 1, 4'h2, 1, 8'h62, "gate_write_r7");
        op(0, 0, 1, 4'h7, 4'hF, 1, 4'h2, 1, 8'h62, "gate_sel0_write");
        op(0, 0, 0, 4'h0, 4'h9, 1, 4'h2, 0, 8'h00, "gate_sel0_hold");
        op(0, 1, 0, 4'h7, 4'h0, 1, 4'h2, 1, 8'h62, "gate_read_r7");

        // Write-through then back-to-back read.
        op(0, 1, 1, 4'h3, 4'h9, 1, 4'h9, 1, 8'h29, "wt_write_r3");
        op(0, 1, 0, 4'h3, 4'h0, 1, 4'h9, 1, 8'h29, "wt_read_r3");

        // Unknown select is inactive.
        op(0, 1'bx, 1, 4'h0, 4'hF, 1, 4'h9, 0, 8'h00, "x_select_hold");
        op(0, 1, 0, 4'h0, 4'h0, 1, 4'h5, 1, 8'h5A, "x_select_read_r0");

        // Reset mid-operation discards the coincident write.
        op(0, 1, 1, 4'h5, 4'hA, 1, 4'hA, 1, 8'hCA, "mid_write_r5");
        op(1, 1, 1, 4'h5, 4'h3, 1, 4'h0, 1, 8'h00, "mid_reset");
        op(0, 1, 0, 4'h5, 4'h0, 1, 4'h0, 1, 8'h00, "mid_read_r5");
        op(0, 1, 0, 4'hF, 4'h0, 1, 4'h0, 1, 8'h00, "mid_read_r15");

        @(negedge clock);
        bus.select = 1'b0;
        guard = 0;
        while (sb.size() > 0 && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        if (sb.size() > 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: %0d entries left, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
